debounced_button_pio: RTL and testbench

Parametrised Avalon-MM input PIO that replaces the plain `pushbuttons` port of the computer system. It provides WIDTH independent input channels, each with a 2-flop synchroniser and a counter-based debouncer. Each channel captures press and/or release edges, and a maskable level interrupt is driven to the Nios II IRQ line. Software reads debounced levels, arms per-channel interrupts and clears captured edges through four 32-bit registers.

---
 rtl/debounced_button_pio.sv | 150 +++++++++++++++
 tb/tb_debounced_button_pio.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/debounced_button_pio.sv
// debounced_button_pio
//   Avalon-MM input PIO for push buttons. Each of WIDTH channels has a 2-flop
//   synchroniser and a counter debouncer. Press and/or release edges are
//   captured per channel, and a maskable level interrupt is raised.
//
// Ports
//   clk_clk            system clock, all state on the rising edge
//   reset_reset_n      asynchronous active-low reset
//   s_address[1:0]     register word address
//   s_read, s_write    access strobes
//   s_writedata[31:0]  write data
//   s_readdata[31:0]   registered read data, valid one edge after s_read
//   irq                registered level interrupt
//   pushbuttons_export raw asynchronous button pins
//
// Register map
//   0 DATA         RO    debounced pressed state
//   1 IRQ_MASK     RW    WIDTH bits
//   2 EDGE_CAPTURE RO/W1C WIDTH bits
//   3 MODE         RW    bit0 capture press, bit1 capture release
//
// Bus handshake: there is no valid/ready pair. s_read or s_write high at a
// rising edge is a complete transfer; the slave never stalls. A read returns
// its data on s_readdata after that edge and holds it until the next read.
// If read and write hit the same edge, the read sees the pre-write value.
module debounced_button_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [1:0]       s_address,
  input  logic             s_read,
  input  logic             s_write,
  input  logic [31:0]      s_writedata,
  output logic [31:0]      s_readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] pushbuttons_export
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  // Pin level that means "not pressed"; also the synchroniser reset value so
  // the first samples after reset look idle.
  localparam logic [WIDTH-1:0] IDLE_PIN = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [1:0]       r_mode;
  logic [31:0]      r_readdata;
  logic             r_irq;

  logic [WIDTH-1:0] w_pressed;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr_mask;
  logic             w_wr_cap;
  logic             w_wr_mode;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  assign w_pressed = r_sync2 ^ IDLE_PIN;

  // A channel accepts its new level on the cycle its counter has reached
  // DEBOUNCE_CYCLES-1 while still differing from the stable level.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = (w_pressed[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
    end
  end

  assign w_set = (w_accept &  w_pressed & {WIDTH{r_mode[0]}})
               | (w_accept & ~w_pressed & {WIDTH{r_mode[1]}});

  assign w_wr_mask = s_write && (s_address == 2'd1);
  assign w_wr_cap  = s_write && (s_address == 2'd2);
  assign w_wr_mode = s_write && (s_address == 2'd3);
  assign w_clr     = w_wr_cap ? s_writedata[WIDTH-1:0] : '0;

  // Upper write-data bits are architecturally ignored.
  assign w_unused_wdata = ^s_writedata;

  always_comb begin
    w_rd_mux = 32'd0;
    case (s_address)
      2'd0:    w_rd_mux = 32'(r_stable);
      2'd1:    w_rd_mux = 32'(r_mask);
      2'd2:    w_rd_mux = 32'(r_cap);
      default: w_rd_mux = {30'd0, r_mode};
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sync1 <= IDLE_PIN;
      r_sync2 <= IDLE_PIN;
    end else begin
      r_sync1 <= pushbuttons_export;
      r_sync2 <= r_sync1;
    end
  end

  // Any return to the stable level clears the counter, so a bounce restarts
  // the count from zero.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_stable <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_pressed[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_stable[i] <= w_pressed[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_mask     <= '0;
      r_cap      <= '0;
      r_mode     <= 2'b01;
      r_readdata <= 32'd0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr_mask) r_mask <= s_writedata[WIDTH-1:0];
      if (w_wr_mode) r_mode <= s_writedata[1:0];
      // Set is OR-ed after the clear so a same-cycle event keeps the bit.
      r_cap <= (r_cap & ~w_clr) | w_set;
      if (s_read) r_readdata <= w_rd_mux;
      r_irq <= |(r_cap & r_mask);
    end
  end

  assign s_readdata = r_readdata;
  assign irq        = r_irq;

endmodule

// File: tb/tb_debounced_button_pio.sv
// tb_debounced_button_pio
//   Bench for debounced_button_pio with WIDTH=4, DEBOUNCE_CYCLES=16,
//   ACTIVE_LOW=1. Inputs are driven and outputs sampled on the falling edge.
//   Read expectations are queued when a read is issued and compared when
//   s_readdata is returned.
module tb_debounced_button_pio;

  localparam int WIDTH = 4;
  localparam int DEB   = 16;

  logic        clk;
  logic        rst_n;
  logic [1:0]  s_address;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic        irq;
  logic [WIDTH-1:0] pins;

  logic [31:0] exp_q[$];
  int n_chk;
  int n_err;

  debounced_button_pio #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW(1)
  ) dut (
    .clk_clk           (clk),
    .reset_reset_n     (rst_n),
    .s_address         (s_address),
    .s_read            (s_read),
    .s_write           (s_write),
    .s_writedata       (s_writedata),
    .s_readdata        (s_readdata),
    .irq               (irq),
    .pushbuttons_export(pins)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run time=%0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    s_address = a;
    s_read    = 1'b1;
    exp_q.push_back(exp);
    tick();
    s_read = 1'b0;
    check_eq(tag, s_readdata, exp_q.pop_front());
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    s_address   = a;
    s_writedata = d;
    s_write     = 1'b1;
    tick();
    s_write = 1'b0;
  endtask

  task automatic rdwr(input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp,
                      input string tag);
    s_address   = a;
    s_writedata = d;
    s_write     = 1'b1;
    s_read      = 1'b1;
    exp_q.push_back(exp);
    tick();
    s_write = 1'b0;
    s_read  = 1'b0;
    check_eq(tag, s_readdata, exp_q.pop_front());
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    s_address = 2'd0;
    s_read = 1'b0;
    s_write = 1'b0;
    s_writedata = 32'd0;
    pins = 4'hF;
    repeat (3) tick();
    check_eq("reset_readdata", s_readdata, 32'd0);
    check_eq("reset_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    tick();

    // reset values of all registers
    rd(2'd0, 32'd0, "reset_data");
    rd(2'd1, 32'd0, "reset_mask");
    rd(2'd2, 32'd0, "reset_cap");
    rd(2'd3, 32'd1, "reset_mode");
    check_eq("reset_irq_run", {31'd0, irq}, 32'd0);

    // register access corner cases
    rdwr(2'd1, 32'h3, 32'd0, "rdwr_prewrite");
    rd(2'd1, 32'h3, "rdwr_postwrite");
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'hF, "mask_upper_bits");
    wr(2'd1, 32'd0);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, 32'h3, "mode_upper_bits");
    wr(2'd3, 32'd1);
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, 32'd0, "data_readonly");

    // clean press on channel 2: stable and capture at edge 18
    pins[2] = 1'b0;
    for (int j = 1; j <= 17; j++) rd(2'd0, 32'd0, "press2_data_early");
    rd(2'd2, 32'd0, "press2_cap_edge17");
    rd(2'd0, 32'h4, "press2_data_edge18");
    rd(2'd2, 32'h4, "press2_cap_edge18");
    check_eq("press2_irq_masked", {31'd0, irq}, 32'd0);
    wr(2'd1, 32'h4);
    check_eq("mask_irq_before", {31'd0, irq}, 32'd0);
    tick();
    check_eq("mask_irq_after", {31'd0, irq}, 32'd1);

    // bounce on channel 0, then a final clean press
    for (int seg = 0; seg < 20; seg++) begin
      pins[0] = (seg % 2 == 0) ? 1'b0 : 1'b1;
      for (int k = 0; k < 5; k++) rd(2'd0, 32'h4, "bounce_data");
    end
    pins[0] = 1'b0;
    for (int j = 1; j <= 18; j++) rd(2'd0, 32'h4, "bounce_final_early");
    rd(2'd0, 32'h5, "bounce_final_edge18");
    rd(2'd2, 32'h5, "bounce_cap");
    wr(2'd2, 32'h1);

    // release-only mode on channel 1
    wr(2'd3, 32'd2);
    pins[1] = 1'b0;
    repeat (40) tick();
    rd(2'd2, 32'h4, "mode2_press_nocap");
    rd(2'd0, 32'h7, "mode2_press_data");
    pins[1] = 1'b1;
    repeat (40) tick();
    rd(2'd2, 32'h6, "mode2_release_cap");
    rd(2'd0, 32'h5, "mode2_release_data");

    // clear racing a press event on channel 2
    wr(2'd2, 32'hF);
    tick();
    check_eq("clear_all_irq", {31'd0, irq}, 32'd0);
    wr(2'd3, 32'd3);
    pins[2] = 1'b1;
    repeat (40) tick();
    rd(2'd2, 32'h4, "release2_cap");
    check_eq("release2_irq", {31'd0, irq}, 32'd1);
    pins[2] = 1'b0;
    repeat (17) tick();
    wr(2'd2, 32'h4);
    check_eq("race_irq_a", {31'd0, irq}, 32'd1);
    tick();
    check_eq("race_irq_b", {31'd0, irq}, 32'd1);
    rd(2'd2, 32'h4, "race_set_wins");
    wr(2'd2, 32'h4);
    check_eq("clean_clr_irq_hold", {31'd0, irq}, 32'd1);
    tick();
    check_eq("clean_clr_irq_drop", {31'd0, irq}, 32'd0);
    rd(2'd2, 32'h0, "clean_clr_cap");

    // reset in the middle of a pending debounce on channel 3
    wr(2'd1, 32'hF);
    pins[0] = 1'b1;
    repeat (40) tick();
    check_eq("pre_reset_irq", {31'd0, irq}, 32'd1);
    rd(2'd0, 32'h4, "pre_reset_data");
    pins[3] = 1'b0;
    repeat (12) tick();
    rst_n = 1'b0;
    #1;
    check_eq("midreset_readdata", s_readdata, 32'd0);
    check_eq("midreset_irq", {31'd0, irq}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    rd(2'd1, 32'd0, "post_reset_mask");
    rd(2'd3, 32'd1, "post_reset_mode");
    for (int j = 3; j <= 18; j++) rd(2'd2, 32'd0, "post_reset_cap_early");
    rd(2'd2, 32'hC, "post_reset_cap_edge18");
    rd(2'd0, 32'hC, "post_reset_data");
    check_eq("post_reset_irq", {31'd0, irq}, 32'd0);

    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
